// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// Emits zero-latency pixel coordinates for the pixel pipeline and then
// realigns hsync/vsync/data_enable/line_start/frame_start with the returned
// rgb_in after PIPE_DELAY clocks plus one output register.
// Optional feature macro: VTG_TEST_PATTERN_EN (8 vertical colour bars on test_mode).
module video_timing_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int PIPE_DELAY = 3,
    parameter int COORD_W    = 11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               test_mode,
    input  logic [23:0]        rgb_in,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               coord_valid,
    output logic               vblank,
    output logic               hsync,
    output logic               vsync,
    output logic               data_enable,
    output logic [23:0]        rgb_out,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_DISP_C = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_DISP_C = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Delay-line payload: {x (pattern build only), hs, vs, de, line_start, frame_start}
`ifdef VTG_TEST_PATTERN_EN
    localparam int PW = 5 + COORD_W;
`else
    localparam int PW = 5;
`endif

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               run;
    logic               hs_act, vs_act, ls_act, fs_act;
    logic [PW-1:0]      stage_in, stage_out;
    logic               dl_hs, dl_vs, dl_de, dl_ls, dl_fs;
    logic [23:0]        rgb_d;

    logic               hsync_q, vsync_q, de_q, ls_q, fs_q;
    logic [23:0]        rgb_q;

    // Decode is suppressed while disabled or held in reset so nothing
    // visible leaks out of the held (0,0) counter state.
    assign run = enable & ~reset;

    // Next raster position: hold at origin when disabled, else advance with wraps
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + COORD_W'(1);
        end else begin
            h_cnt_d = h_cnt_q + COORD_W'(1);
        end
    end

    // Raster counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Coordinate-domain decode of the current counters (zero latency)
    always_comb begin
        coord_valid = run && (h_cnt_q < H_DISP_C) && (v_cnt_q < V_DISP_C);
        pixel_x     = coord_valid ? h_cnt_q : '0;
        pixel_y     = coord_valid ? v_cnt_q : '0;
        vblank      = run && (v_cnt_q >= V_DISP_C);
        hs_act      = run && (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        vs_act      = run && (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
        ls_act      = run && (h_cnt_q == '0);
        fs_act      = ls_act && (v_cnt_q == '0);
    end

`ifdef VTG_TEST_PATTERN_EN
    assign stage_in = {pixel_x, hs_act, vs_act, coord_valid, ls_act, fs_act};
`else
    assign stage_in = {hs_act, vs_act, coord_valid, ls_act, fs_act};
`endif

    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign stage_out = stage_in;
        end else begin : g_delay
            logic [PW-1:0] pipe_q [PIPE_DELAY];

            // Shift register matching the pixel pipeline latency; keeps
            // shifting while disabled so the outputs drain to idle.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= stage_in;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign stage_out = pipe_q[PIPE_DELAY-1];
        end
    endgenerate

    assign dl_hs = stage_out[4];
    assign dl_vs = stage_out[3];
    assign dl_de = stage_out[2];
    assign dl_ls = stage_out[1];
    assign dl_fs = stage_out[0];

`ifdef VTG_TEST_PATTERN_EN
    logic [COORD_W-1:0] dl_x;
    logic [COORD_W+2:0] bar_quot;
    logic [2:0]         bar_idx;
    logic               unused_bar_bits;

    assign dl_x            = stage_out[PW-1:5];
    assign bar_quot        = {dl_x, 3'b000} / (COORD_W+3)'(H_DISPLAY);
    assign bar_idx         = bar_quot[2:0];
    assign unused_bar_bits = ^bar_quot[COORD_W+2:3];

    // Pixel source: bars (white..black) replace rgb_in in test mode; blanked outside de
    always_comb begin
        rgb_d = 24'h000000;
        if (dl_de) begin
            if (test_mode) begin
                rgb_d = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            end else begin
                rgb_d = rgb_in;
            end
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;

    // Pixel source: returned rgb_in, blanked outside de
    always_comb begin
        rgb_d = 24'h000000;
        if (dl_de) begin
            rgb_d = rgb_in;
        end
    end
`endif

    // Output register: sync polarity applied here so outputs are glitch-free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync_q <= ~HS_ON;
            vsync_q <= ~VS_ON;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            rgb_q   <= 24'h000000;
        end else begin
            hsync_q <= dl_hs ? HS_ON : ~HS_ON;
            vsync_q <= dl_vs ? VS_ON : ~VS_ON;
            de_q    <= dl_de;
            ls_q    <= dl_ls;
            fs_q    <= dl_fs;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign data_enable = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign rgb_out     = rgb_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI/VGA output path. It produces pixel coordinates for the framebuffer/pixel pipeline and then realigns sync, data-enable and returned RGB data after a configurable pipeline delay. It replaces the fixed 640x480 sync logic and supports:
- any modeline;
- selectable sync polarity;
- a clean enable/restart;
- a frame-domain blanking flag for safe framebuffer updates.

## Interface
Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_DISPLAY, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level
- PIPE_DELAY, 3, clocks from coordinate output to matching rgb_in; 0..15
- COORD_W, 11, width of the counters and coordinates

Ports:
- Reset and clock: reset reset, asynchronous, active-high; clock clock.
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run raster; low holds generator idle
- test_mode  in  1  select colour bars (see Configuration)
- rgb_in  in  24  pixel data, {R,G,B}, valid PIPE_DELAY clocks after its coordinate
- pixel_x  out  COORD_W  active-area x coordinate, 0 outside active area
- pixel_y  out  COORD_W  active-area y coordinate, 0 outside active area
- coord_valid  out  1  pixel_x/pixel_y denote a visible pixel
- vblank  out  1  coordinate-domain, v counter >= V_DISPLAY
- hsync  out  1  aligned horizontal sync
- vsync  out  1  aligned vertical sync
- data_enable  out  1  aligned active-video flag
- rgb_out  out  24  aligned pixel data
- line_start  out  1  aligned one-clock pulse at h=0 of every line
- frame_start  out  1  aligned one-clock pulse at (0,0)

## Operation
- Totals are derived: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK.
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) are registers.
- Line and frame order: display, front porch, sync, back porch. The origin is the first visible pixel.
- h_cnt wraps at H_TOTAL-1. v_cnt advances only on an h wrap and wraps at V_TOTAL-1. Both wraps occur on the same edge at end of frame.
- Coordinate stage, a decode of the current counters:
  - coord_valid = (h_cnt<H_DISPLAY)&&(v_cnt<V_DISPLAY).
  - pixel_x/pixel_y = h_cnt/v_cnt when coord_valid, else 0.
  - vblank = (v_cnt>=V_DISPLAY).
- Sync decode:
  - hsync is asserted (=HS_POL) for h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vsync is asserted (=VS_POL) for whole lines v_cnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
- The decoded hsync, vsync, de, line_start and frame_start pass through a PIPE_DELAY-stage shift register. They are then registered once more together with rgb_out.
- rgb_out = delayed de ? rgb_in : 24'h000000.
- enable low:
  - counters are forced to (0,0) and held;
  - coord_valid=0, and all decoded signals are inactive;
  - the delay line keeps shifting, so outputs drain to idle after the output latency.
- enable rising: the first coordinate cycle is (0,0), and frame_start follows after the output latency.
- Reset (asynchronous, any time including mid-line):
  - counters go to 0;
  - all delay stages go inactive;
  - hsync=~HS_POL, vsync=~VS_POL;
  - data_enable, line_start, frame_start, coord_valid and vblank are 0;
  - rgb_out=0, pixel_x=pixel_y=0.
- After reset release with enable high, the first coordinate cycle is (0,0).

## Timing
- Coordinate outputs: zero latency relative to the counters.
- Output latency: hsync, vsync, data_enable, rgb_out, line_start and frame_start represent the position of PIPE_DELAY+1 clocks earlier.
- rgb_in sampled at edge n pairs with the coordinate of edge n-PIPE_DELAY.
- Line period is H_TOTAL clocks; frame period is H_TOTAL*V_TOTAL clocks; there is no jitter.
- vblank is high for V_TOTAL-V_DISPLAY whole lines. It rises on the first clock of line V_DISPLAY.
- All outputs are glitch-free registered signals.

## Configuration
- VTG_TEST_PATTERN_EN defined, with test_mode high:
  - the rgb_out source is replaced by 8 vertical bars, each H_DISPLAY/8 wide, index = delayed x*8/H_DISPLAY;
  - bar order: white, yellow, cyan, green, magenta, red, blue, black;
  - bar levels are 8'hFF/8'h00;
  - blanking, and all timing, are unchanged.
- VTG_TEST_PATTERN_EN undefined: test_mode is ignored and rgb_out is always the gated rgb_in.

## Test plan
- Defaults, enable=1, release reset:
  - the first cycle shows coord_valid=1, (0,0);
  - data_enable and frame_start rise exactly 4 clocks later;
  - frame_start is one clock wide.
- Line timing:
  - hsync low for exactly 96 clocks, starting 660 clocks after h=0 of the coordinates;
  - line_start period 800;
  - data_enable high 640 clocks per active line.
- Frame timing:
  - vsync low for 1600 clocks starting at line 490;
  - frame_start period 420000 clocks;
  - vblank high for lines 480-524;
  - exactly 307200 data_enable clocks per frame.
- rgb_in fixed 24'h123456: rgb_out=24'h123456 exactly when data_enable=1, else 24'h000000. Also drop enable mid-frame: outputs idle after 4 clocks, and restart produces (0,0).
- Assert reset at (h=300,v=100): all outputs take their reset values asynchronously. After release, counting restarts at (0,0).
- Override H 8/2/2/2, V 4/1/1/1, PIPE_DELAY 0, HS_POL=VS_POL=1:
  - hsync high at outputs for h=10-11, line period 14;
  - vsync high for line 5.
  - With VTG_TEST_PATTERN_EN and test_mode=1: the defaults build gives rgb_out=24'hFFFF00 at x=80..159.
